avs_csr_router: RTL

AVS_CSR_ROUTER -- requirements
Module: avs_csr_router

---
 rtl/avs_csr_router.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/avs_csr_router.sv
// ============================================================================
// Module   : avs_csr_router
// Function : Avalon-MM CSR router, one slave in, NUM_PORTS CSR ports out,
//            with read timeout, error data and a saturating error log.
// Revision : 1.0
// ============================================================================
`default_nettype none

module avs_csr_router #(
  parameter int          NUM_PORTS      = 4,
  parameter int          DECODE_LSB     = 24,
  parameter int          DECODE_WIDTH   = 5,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic                    avs_waitrequest,
  output logic [31:0]             avs_readdata,
  output logic                    avs_readdatavalid,
  output logic [31:0]             port_address,
  output logic [31:0]             port_writedata,
  output logic [NUM_PORTS-1:0]    port_write,
  output logic [NUM_PORTS-1:0]    port_read,
  input  logic [NUM_PORTS*32-1:0] port_readdata,
  input  logic [NUM_PORTS-1:0]    port_readdatavalid,
  output logic [15:0]             err_count,
  output logic [31:0]             last_err_addr
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR      = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam int                    c_TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TW-1:0]       c_TMAX      = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DECODE_WIDTH:0] c_NUM_PORTS = NUM_PORTS[DECODE_WIDTH:0];

  logic [1:0]           r_state;
  logic [c_TW-1:0]      r_timer;
  logic [NUM_PORTS-1:0] r_sel;
  logic [NUM_PORTS-1:0] r_port_write;
  logic [NUM_PORTS-1:0] r_port_read;
  logic [31:0]          r_paddr;
  logic [31:0]          r_pwdata;
  logic [31:0]          r_rdata;
  logic                 r_rvalid;
  logic [15:0]          r_err_count;
  logic [31:0]          r_last_err;

  logic [DECODE_WIDTH-1:0] w_idx;
  logic                    w_mapped;
  logic [NUM_PORTS-1:0]    w_onehot;
  logic                    w_accept;
  logic                    w_sel_valid;
  logic [31:0]             w_sel_data;
  logic                    w_timeout;
  logic                    w_err_event;
  logic [31:0]             w_err_addr;

  assign w_idx    = avs_address[DECODE_LSB +: DECODE_WIDTH];
  assign w_mapped = ({1'b0, w_idx} < c_NUM_PORTS);
  assign w_accept = (r_state == S_IDLE) && (avs_write || avs_read);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_idx == DECODE_WIDTH'(i)) w_onehot[i] = 1'b1;
    end
  end

  // r_sel is one-hot for a mapped read, so an AND-OR mux picks the port.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_sel_data = w_sel_data | (port_readdata[i*32 +: 32] & {32{r_sel[i]}});
    end
  end

  assign w_sel_valid = |(port_readdatavalid & r_sel);
  assign w_timeout   = (r_state == S_RD_WAIT) && !w_sel_valid && (r_timer == c_TMAX);

  // One error per accepted request at most: unmapped target, or a read
  // that collided with a write (the write still goes ahead).
  assign w_err_event = (w_accept && ((avs_write && (avs_read || !w_mapped)) ||
                                     (!avs_write && !w_mapped))) || w_timeout;
  assign w_err_addr  = (r_state == S_IDLE) ? avs_address : r_paddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_sel        <= '0;
      r_port_write <= '0;
      r_port_read  <= '0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_err_count  <= '0;
      r_last_err   <= '0;
    end else begin
      r_port_write <= '0;
      r_port_read  <= '0;
      r_rvalid     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_paddr  <= avs_address;
            r_pwdata <= avs_writedata;
            r_sel    <= w_onehot;
            if (avs_write) begin
              r_state      <= S_WR;
              r_port_write <= w_mapped ? w_onehot : '0;
            end else if (w_mapped) begin
              r_state     <= S_RD_WAIT;
              r_port_read <= w_onehot;
              r_timer     <= '0;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WR: r_state <= S_IDLE;
        S_RD_WAIT: begin
          if (w_sel_valid) begin
            r_rdata  <= w_sel_data;
            r_rvalid <= 1'b1;
            r_state  <= S_IDLE;
          end else if (w_timeout) begin
            r_rdata  <= ERR_DATA;
            r_rvalid <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          r_rdata  <= ERR_DATA;
          r_rvalid <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_err_event) begin
        r_err_count <= (r_err_count == 16'hFFFF) ? 16'hFFFF : r_err_count + 16'd1;
        r_last_err  <= w_err_addr;
      end
    end
  end

  // Reset holds the bus stalled; release is immediate once rst drops.
  assign avs_waitrequest   = rst || (r_state != S_IDLE);
  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign port_address      = r_paddr;
  assign port_writedata    = r_pwdata;
  assign port_write        = r_port_write;
  assign port_read         = r_port_read;
  assign err_count         = r_err_count;
  assign last_err_addr     = r_last_err;

endmodule

`default_nettype wire
